ma_stage: RTL and testbench
===========================

# ma_stage

Memory-access stage of the RV32I pipeline and the consumer of the EX→MA register bundle. It turns load/store commands into requests on a req/ack data-memory bus, and performs byte-lane alignment and sign/zero extension of load data. It registers the write-back result plus a second delayed copy for operand forwarding, and raises a stall request while a memory access is outstanding. It sits between the execution stage and the register-file write-back.

## Interface
Parameters: none.
Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- cmd_ld_ma  in  1  load in MA
- cmd_st_ma  in  1  store in MA (already purged on jump)
- rd_adr_ma  in  5  destination register
- rd_data_ma  in  32  ALU result; byte address for ld/st
- wbk_rd_reg_ma  in  1  write-back enable
- st_data_ma  in  32  store data (unaligned, LSB-justified)
- ldst_code_ma  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- stall  in  1  global stall; ma_stall is OR'ed into it externally
- rst_pipe  in  1  synchronous pipeline flush
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_adr  out  30  word address [31:2]
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access done; may arrive in the request cycle
- dmem_rdata  in  32  read word, valid with ack
- ma_stall  out  1  access pending
- ma_fault  out  1  registered one-cycle pulse for a misaligned or illegal-code access
- rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb  out  5/1/32  write-back stage
- rd_adr_wb2, wbk_rd_reg_wb2, wbk_data_wb2  out  5/1/32  one stage later, for forwarding

## Operation
- An access is `cmd_ld_ma | cmd_st_ma`. Its offset is `a = rd_data_ma[1:0]`.
- Fault conditions:
  - halfword access with `a[0]=1`
  - word access with `a≠0`
  - any ldst_code of 011, 110 or 111
  - A faulting access issues no request, forces the write-back enable to 0, and pulses ma_fault.
- Store lanes:
  - byte: be = 1<<a, data replicated ×4
  - half: be = 0011 or 1100, data replicated ×2
  - word: be = 1111
- Load data selection:
  - byte or half lane chosen by a.
  - Codes 000 and 001 sign-extend; codes 100 and 101 zero-extend.
- Write-back data:
  - load: the extended rdata
  - otherwise: rd_data_ma
  - wbk_rd_reg_wb = wbk_rd_reg_ma & ~fault.
- FSM states IDLE, BUSY, HOLD, DROP:
  - IDLE: for a non-faulting access with ~rst_pipe, dmem_req is asserted combinationally.
    - ack with ~stall: WB registers load, stay in IDLE.
    - ack with stall (other source): capture rdata into the hold register, go to HOLD.
    - no ack: go to BUSY.
  - BUSY: dmem_req=1.
    - ack: behaves as the IDLE ack cases.
    - rst_pipe: go to DROP.
  - HOLD: dmem_req=0. When ~stall, WB registers load from the hold register, go to IDLE.
  - DROP: dmem_req stays 1 until ack, and the result is discarded. On ack go to IDLE. A started access is never abandoned.
- ma_stall = dmem_req & ~dmem_ack.
- Output registers: WB and WB2 registers advance only when ~stall. rst_pipe clears them.

## Timing
- Reset values:
  - all *_wb and *_wb2 outputs are 0.
  - ma_fault is 0.
  - state is IDLE.
  - dmem_req, dmem_we and dmem_be are 0 because the inputs are 0.
- Latency:
  - zero-wait memory: result appears on wbk_data_wb at the next edge, and on wbk_data_wb2 one edge later.
  - N wait cycles: ma_stall is high for exactly N cycles.
- dmem_adr, dmem_be and dmem_wdata stay stable while dmem_req is high, because stall freezes the EX→MA registers.
- A non-memory instruction passes through in 1 cycle and never stalls.
- rst_pipe with stall: rst_pipe has priority on the output registers.
- rst_pipe in IDLE: suppresses a new request.

## Structure
- Shared package holds:
  - LDST code constants (B, H, W, BU, HU)
  - FSM state encoding (2 bits)
- Natural sub-module: `ma_lane_align`, a combinational block that computes be, wdata, load extension and the fault flag from code, a, st_data and rdata.

## Test plan
- LW at 0x100, ack in the same cycle, rdata=0xDEADBEEF → wbk_data_wb=0xDEADBEEF after 1 cycle; ma_stall never asserted.
- LB at 0x103, rdata=0x80000000 → wbk_data_wb=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with st_data=0x1234, 3 wait cycles → be=1100, wdata=0x12341234, ma_stall high for 3 cycles, wbk_rd_reg_wb=0.
- LW at 0x101 → no dmem_req, ma_fault pulses once, wbk_rd_reg_wb=0.
- Ack arrives while an external stall is held 2 more cycles → HOLD. Data appears on wbk_data_wb only on the edge after stall drops.
- rst_pipe during BUSY for a store → dmem_req held until ack, no write-back, FSM ends in IDLE. Async rst mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/ma_stage_pkg.sv
//==============================================================================
// Module   : ma_stage_pkg
// Brief    : Load/store size codes, FSM encoding and bus command type for MA.
// Revision : 1.0
//==============================================================================
`default_nettype none

package ma_stage_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_HOLD = 2'b10,
        ST_DROP = 2'b11
    } ma_state_e;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/ma_stage_if.sv
//==============================================================================
// Module   : ma_stage_if
// Brief    : Request/acknowledge data-memory bus between MA and memory.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface ma_stage_if;
    logic        req;
    logic        we;
    logic [29:0] adr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, adr, be, wdata, input ack, rdata);
    modport slave  (input req, we, adr, be, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/ma_lane_align.sv
//==============================================================================
// Module   : ma_lane_align
// Brief    : Byte-lane enables, store replication, load extension, fault flag.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ma_lane_align
    import ma_stage_pkg::*;
(
    input  logic [2:0]  code_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{adr_i, 3'b000} +: 8];
    assign half_sel = adr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // code_i[2] distinguishes the unsigned variants
    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
        fault_o   = 1'b0;
        case (code_i)
            LDST_B, LDST_BU: begin
                be_o      = 4'b0001 << adr_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{byte_sel[7] & ~code_i[2]}}, byte_sel};
            end
            LDST_H, LDST_HU: begin
                fault_o   = adr_i[0];
                be_o      = adr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{half_sel[15] & ~code_i[2]}}, half_sel};
            end
            LDST_W: begin
                fault_o = |adr_i;
                be_o    = 4'b1111;
            end
            default: fault_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ma_stage.sv
//==============================================================================
// Module   : ma_stage
// Brief    : RV32I memory-access stage: req/ack data bus, WB and WB2 registers.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ma_stage
    import ma_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_ld_ma,
    input  logic              cmd_st_ma,
    input  logic [4:0]        rd_adr_ma,
    input  logic [31:0]       rd_data_ma,
    input  logic              wbk_rd_reg_ma,
    input  logic [31:0]       st_data_ma,
    input  logic [2:0]        ldst_code_ma,
    input  logic              stall,
    input  logic              rst_pipe,
    ma_stage_if.master        dmem,
    output logic              ma_stall,
    output logic              ma_fault,
    output logic [4:0]        rd_adr_wb,
    output logic              wbk_rd_reg_wb,
    output logic [31:0]       wbk_data_wb,
    output logic [4:0]        rd_adr_wb2,
    output logic              wbk_rd_reg_wb2,
    output logic [31:0]       wbk_data_wb2
);

    ma_state_e   state_q, state_d;
    dmem_cmd_t   cmd_q, cmd_live, cmd_bus;
    logic [31:0] hold_q;
    logic        hold_load;
    logic        access, fault, issue, advance, capture;
    logic        align_fault;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, ld_data;
    logic [31:0] wb_data_d;
    logic        wb_en_d;
    logic        fault_q;
    logic [4:0]  rd_adr_wb_q, rd_adr_wb2_q;
    logic        wbk_wb_q, wbk_wb2_q;
    logic [31:0] data_wb_q, data_wb2_q;

    ma_lane_align u_align (
        .code_i    (ldst_code_ma),
        .adr_i     (rd_data_ma[1:0]),
        .st_data_i (st_data_ma),
        .rdata_i   (dmem.rdata),
        .be_o      (align_be),
        .wdata_o   (align_wdata),
        .ld_data_o (ld_data),
        .fault_o   (align_fault)
    );

    assign access  = cmd_ld_ma | cmd_st_ma;
    assign fault   = access & align_fault;
    assign issue   = access & ~fault & ~rst_pipe;
    assign capture = (state_q == ST_IDLE) & issue & ~dmem.ack;

    assign cmd_live = '{we: cmd_st_ma, adr: rd_data_ma[31:2], be: align_be, wdata: align_wdata};
    // Once an access is outstanding the bus replays the captured command, so a
    // flush of the upstream registers cannot disturb it.
    assign cmd_bus  = (state_q == ST_IDLE) ? cmd_live : cmd_q;

    assign dmem.req   = ~rst & (((state_q == ST_IDLE) & issue) |
                                (state_q == ST_BUSY) | (state_q == ST_DROP));
    assign dmem.we    = dmem.req & cmd_bus.we;
    assign dmem.be    = dmem.req ? cmd_bus.be : 4'b0000;
    assign dmem.adr   = cmd_bus.adr;
    assign dmem.wdata = cmd_bus.wdata;

    assign ma_stall = dmem.req & ~dmem.ack;
    assign advance  = ~stall & ~ma_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (!dmem.ack)   state_d = ST_BUSY;
                    else if (stall) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem.ack) begin
                    if (rst_pipe)   state_d = ST_IDLE;
                    else if (stall) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end else        state_d = ST_IDLE;
                end else if (rst_pipe) begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: if (rst_pipe || !stall) state_d = ST_IDLE;
            ST_DROP: if (dmem.ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_data_d = rd_data_ma;
        wb_en_d   = wbk_rd_reg_ma & ~fault;
        if (state_q == ST_HOLD)
            wb_data_d = hold_q;
        else if (cmd_ld_ma && !fault && dmem.ack &&
                 (state_q == ST_IDLE || state_q == ST_BUSY))
            wb_data_d = ld_data;
        // An access seen during DROP was never issued; it must not retire.
        if (state_q == ST_DROP && access)
            wb_en_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q        <= '0;
            hold_q       <= '0;
            fault_q      <= 1'b0;
            rd_adr_wb_q  <= '0;
            wbk_wb_q     <= 1'b0;
            data_wb_q    <= '0;
            rd_adr_wb2_q <= '0;
            wbk_wb2_q    <= 1'b0;
            data_wb2_q   <= '0;
        end else begin
            if (capture)   cmd_q  <= cmd_live;
            if (hold_load) hold_q <= ld_data;
            fault_q <= fault & ~rst_pipe & ~stall;
            if (rst_pipe) begin
                rd_adr_wb_q  <= '0;
                wbk_wb_q     <= 1'b0;
                data_wb_q    <= '0;
                rd_adr_wb2_q <= '0;
                wbk_wb2_q    <= 1'b0;
                data_wb2_q   <= '0;
            end else if (advance) begin
                rd_adr_wb_q  <= rd_adr_ma;
                wbk_wb_q     <= wb_en_d;
                data_wb_q    <= wb_data_d;
                rd_adr_wb2_q <= rd_adr_wb_q;
                wbk_wb2_q    <= wbk_wb_q;
                data_wb2_q   <= data_wb_q;
            end
        end
    end

    assign ma_fault       = fault_q;
    assign rd_adr_wb      = rd_adr_wb_q;
    assign wbk_rd_reg_wb  = wbk_wb_q;
    assign wbk_data_wb    = data_wb_q;
    assign rd_adr_wb2     = rd_adr_wb2_q;
    assign wbk_rd_reg_wb2 = wbk_wb2_q;
    assign wbk_data_wb2   = data_wb2_q;

endmodule

`default_nettype wire

// File: tb/tb_ma_stage.sv
//==============================================================================
// Module   : tb_ma_stage
// Brief    : Directed self-checking bench for the memory-access stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ma_stage;
    import ma_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, rst_pipe, ext_stall;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        stall;
    logic        ma_stall, ma_fault;
    logic [4:0]  rd_adr_wb, rd_adr_wb2;
    logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;
    logic [31:0] wbk_data_wb, wbk_data_wb2;

    int n_checks = 0;
    int n_fail   = 0;

    ma_stage_if dmem_if ();

    assign stall = ext_stall | ma_stall;

    ma_stage dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_ld_ma      (cmd_ld_ma),
        .cmd_st_ma      (cmd_st_ma),
        .rd_adr_ma      (rd_adr_ma),
        .rd_data_ma     (rd_data_ma),
        .wbk_rd_reg_ma  (wbk_rd_reg_ma),
        .st_data_ma     (st_data_ma),
        .ldst_code_ma   (ldst_code_ma),
        .stall          (stall),
        .rst_pipe       (rst_pipe),
        .dmem           (dmem_if.master),
        .ma_stall       (ma_stall),
        .ma_fault       (ma_fault),
        .rd_adr_wb      (rd_adr_wb),
        .wbk_rd_reg_wb  (wbk_rd_reg_wb),
        .wbk_data_wb    (wbk_data_wb),
        .rd_adr_wb2     (rd_adr_wb2),
        .wbk_rd_reg_wb2 (wbk_rd_reg_wb2),
        .wbk_data_wb2   (wbk_data_wb2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_instr(input logic ld, input logic st, input logic [4:0] rd,
                             input logic [31:0] data, input logic wbk,
                             input logic [31:0] sd, input logic [2:0] code);
        cmd_ld_ma     = ld;
        cmd_st_ma     = st;
        rd_adr_ma     = rd;
        rd_data_ma    = data;
        wbk_rd_reg_ma = wbk;
        st_data_ma    = sd;
        ldst_code_ma  = code;
    endtask

    task automatic bubble();
        set_instr(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (wbk_data_wb !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wbk_data_wb); end
        n_checks++; if (wbk_rd_reg_wb !== 1'b0 || rd_adr_wb !== 5'd0) begin n_fail++; $display("FAIL reset_wb_ctl: got %b/%0d want 0/0", wbk_rd_reg_wb, rd_adr_wb); end
        n_checks++; if (wbk_data_wb2 !== 32'h0 || wbk_rd_reg_wb2 !== 1'b0) begin n_fail++; $display("FAIL reset_wb2: got %h/%b want 0/0", wbk_data_wb2, wbk_rd_reg_wb2); end
        n_checks++; if (ma_fault !== 1'b0 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL reset_flags: fault %b stall %b want 0", ma_fault, ma_stall); end
        n_checks++; if (dmem_if.req !== 1'b0 || dmem_if.we !== 1'b0 || dmem_if.be !== 4'b0000) begin n_fail++; $display("FAIL reset_bus: req %b we %b be %b want 0", dmem_if.req, dmem_if.we, dmem_if.be); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_lw_zero_wait();
        set_instr(1'b1, 1'b0, 5'd5, 32'h100, 1'b1, 32'h0, LDST_W);
        dmem_if.ack = 1'b1; dmem_if.rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL lw_req: req %b stall %b want 1/0", dmem_if.req, ma_stall); end
        n_checks++; if (dmem_if.adr !== 30'h40 || dmem_if.be !== 4'b1111 || dmem_if.we !== 1'b0) begin n_fail++; $display("FAIL lw_bus: adr %h be %b we %b want 40/1111/0", dmem_if.adr, dmem_if.be, dmem_if.we); end
        step();
        n_checks++; if (wbk_data_wb !== 32'hDEADBEEF || wbk_rd_reg_wb !== 1'b1 || rd_adr_wb !== 5'd5) begin n_fail++; $display("FAIL lw_wb: got %h/%b/%0d want deadbeef/1/5", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb); end
        bubble(); dmem_if.ack = 1'b0;
        step();
        n_checks++; if (wbk_data_wb2 !== 32'hDEADBEEF || rd_adr_wb2 !== 5'd5 || wbk_rd_reg_wb2 !== 1'b1) begin n_fail++; $display("FAIL lw_wb2: got %h/%0d/%b want deadbeef/5/1", wbk_data_wb2, rd_adr_wb2, wbk_rd_reg_wb2); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  codes [4] = '{LDST_B, LDST_BU, LDST_H, LDST_HU};
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rdat  [4] = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h80010000};
        logic [31:0] expd  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        logic [3:0]  expbe [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, 1'b0, 5'd10 + 5'(i), addrs[i], 1'b1, 32'h0, codes[i]);
            dmem_if.ack = 1'b1; dmem_if.rdata = rdat[i];
            @(negedge clk);
            n_checks++; if (dmem_if.be !== expbe[i]) begin n_fail++; $display("FAIL ld_be[%0d]: got %b want %b", i, dmem_if.be, expbe[i]); end
            step();
            n_checks++; if (wbk_data_wb !== expd[i]) begin n_fail++; $display("FAIL ld_ext[%0d]: got %h want %h", i, wbk_data_wb, expd[i]); end
        end
        bubble(); dmem_if.ack = 1'b0;
        step();
    endtask

    task automatic test_store_wait();
        int stall_cnt = 0;
        set_instr(1'b0, 1'b0, 5'd2, 32'h77, 1'b1, 32'h0, 3'b000);
        step();
        set_instr(1'b0, 1'b1, 5'd0, 32'h102, 1'b0, 32'h00001234, LDST_H);
        for (int c = 0; c < 4; c++) begin
            dmem_if.ack = (c == 3);
            @(negedge clk);
            if (ma_stall) stall_cnt++;
            n_checks++; if (dmem_if.req !== 1'b1 || dmem_if.we !== 1'b1 || dmem_if.be !== 4'b1100 || dmem_if.wdata !== 32'h12341234 || dmem_if.adr !== 30'h40) begin
                n_fail++; $display("FAIL sh_bus[%0d]: req %b we %b be %b wdata %h adr %h want 1/1/1100/12341234/40", c, dmem_if.req, dmem_if.we, dmem_if.be, dmem_if.wdata, dmem_if.adr);
            end
            step();
            if (c == 1) begin
                n_checks++; if (wbk_rd_reg_wb !== 1'b1 || wbk_data_wb !== 32'h77) begin n_fail++; $display("FAIL sh_freeze: got %b/%h want 1/77", wbk_rd_reg_wb, wbk_data_wb); end
            end
        end
        n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 3", stall_cnt); end
        n_checks++; if (wbk_rd_reg_wb !== 1'b0) begin n_fail++; $display("FAIL sh_wbk: got %b want 0", wbk_rd_reg_wb); end
        bubble(); dmem_if.ack = 1'b0;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0) begin n_fail++; $display("FAIL sh_idle: req %b want 0", dmem_if.req); end
        step();
    endtask

    task automatic test_fault();
        set_instr(1'b0, 1'b0, 5'd7, 32'hCAFEF00D, 1'b1, 32'h0, 3'b000);
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL alu_nostall: req %b stall %b want 0/0", dmem_if.req, ma_stall); end
        step();
        n_checks++; if (wbk_data_wb !== 32'hCAFEF00D || wbk_rd_reg_wb !== 1'b1 || rd_adr_wb !== 5'd7) begin n_fail++; $display("FAIL alu_pass: got %h/%b/%0d want cafef00d/1/7", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb); end
        set_instr(1'b1, 1'b0, 5'd9, 32'h101, 1'b1, 32'h0, LDST_W);
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0 || ma_fault !== 1'b0) begin n_fail++; $display("FAIL mis_noreq: req %b fault %b want 0/0", dmem_if.req, ma_fault); end
        step();
        n_checks++; if (ma_fault !== 1'b1 || wbk_rd_reg_wb !== 1'b0 || rd_adr_wb !== 5'd9) begin n_fail++; $display("FAIL mis_fault: fault %b wbk %b adr %0d want 1/0/9", ma_fault, wbk_rd_reg_wb, rd_adr_wb); end
        n_checks++; if (wbk_data_wb2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_wb2: got %h want cafef00d", wbk_data_wb2); end
        bubble();
        step();
        n_checks++; if (ma_fault !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: fault %b want 0", ma_fault); end
        set_instr(1'b1, 1'b0, 5'd9, 32'h100, 1'b1, 32'h0, 3'b011);
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0) begin n_fail++; $display("FAIL ill_noreq: req %b want 0", dmem_if.req); end
        step();
        n_checks++; if (ma_fault !== 1'b1 || wbk_rd_reg_wb !== 1'b0) begin n_fail++; $display("FAIL ill_fault: fault %b wbk %b want 1/0", ma_fault, wbk_rd_reg_wb); end
        bubble();
        step();
    endtask

    task automatic test_hold();
        set_instr(1'b0, 1'b0, 5'd1, 32'hAAAA5555, 1'b1, 32'h0, 3'b000);
        step();
        set_instr(1'b1, 1'b0, 5'd3, 32'h200, 1'b1, 32'h0, LDST_W);
        ext_stall = 1'b1; dmem_if.ack = 1'b1; dmem_if.rdata = 32'h11223344;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1) begin n_fail++; $display("FAIL hold_req: req %b want 1", dmem_if.req); end
        step();
        dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (dmem_if.req !== 1'b0 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL hold_noreq[%0d]: req %b stall %b want 0/0", c, dmem_if.req, ma_stall); end
            n_checks++; if (wbk_data_wb !== 32'hAAAA5555) begin n_fail++; $display("FAIL hold_wait[%0d]: got %h want aaaa5555", c, wbk_data_wb); end
            step();
        end
        n_checks++; if (wbk_data_wb !== 32'hAAAA5555) begin n_fail++; $display("FAIL hold_late: got %h want aaaa5555", wbk_data_wb); end
        ext_stall = 1'b0;
        step();
        n_checks++; if (wbk_data_wb !== 32'h11223344 || rd_adr_wb !== 5'd3 || wbk_rd_reg_wb !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %h/%0d/%b want 11223344/3/1", wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb); end
        set_instr(1'b1, 1'b0, 5'd4, 32'h204, 1'b1, 32'h0, LDST_W);
        dmem_if.ack = 1'b1; dmem_if.rdata = 32'h0BADF00D;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1) begin n_fail++; $display("FAIL hold_back_idle: req %b want 1", dmem_if.req); end
        step();
        n_checks++; if (wbk_data_wb !== 32'h0BADF00D) begin n_fail++; $display("FAIL back_to_back: got %h want 0badf00d", wbk_data_wb); end
        bubble(); dmem_if.ack = 1'b0;
        step();
    endtask

    task automatic test_drop();
        set_instr(1'b0, 1'b0, 5'd6, 32'h1234, 1'b1, 32'h0, 3'b000);
        step();
        set_instr(1'b0, 1'b1, 5'd0, 32'h300, 1'b0, 32'h55, LDST_W);
        step();
        rst_pipe = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1 || ma_stall !== 1'b1) begin n_fail++; $display("FAIL drop_busy: req %b stall %b want 1/1", dmem_if.req, ma_stall); end
        step();
        n_checks++; if (wbk_rd_reg_wb !== 1'b0 || wbk_data_wb !== 32'h0) begin n_fail++; $display("FAIL drop_flush: got %b/%h want 0/0", wbk_rd_reg_wb, wbk_data_wb); end
        rst_pipe = 1'b0;
        bubble();
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1 || dmem_if.we !== 1'b1 || dmem_if.adr !== 30'hC0 || dmem_if.wdata !== 32'h55) begin n_fail++; $display("FAIL drop_hold: req %b we %b adr %h wdata %h want 1/1/c0/55", dmem_if.req, dmem_if.we, dmem_if.adr, dmem_if.wdata); end
        step();
        dmem_if.ack = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b1 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL drop_ack: req %b stall %b want 1/0", dmem_if.req, ma_stall); end
        step();
        dmem_if.ack = 1'b0;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0 || wbk_rd_reg_wb !== 1'b0) begin n_fail++; $display("FAIL drop_idle: req %b wbk %b want 0/0", dmem_if.req, wbk_rd_reg_wb); end
        step();
    endtask

    task automatic test_rst_pipe_idle();
        set_instr(1'b1, 1'b0, 5'd5, 32'h100, 1'b1, 32'h0, LDST_W);
        rst_pipe = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem_if.req !== 1'b0 || ma_stall !== 1'b0) begin n_fail++; $display("FAIL flush_noreq: req %b stall %b want 0/0", dmem_if.req, ma_stall); end
        step();
        rst_pipe = 1'b0;
        bubble();
        step();
    endtask

    task automatic test_async_reset();
        set_instr(1'b0, 1'b0, 5'd8, 32'h5A5A, 1'b1, 32'h0, 3'b000);
        step();
        step();
        set_instr(1'b1, 1'b0, 5'd8, 32'h400, 1'b1, 32'h0, LDST_W);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (wbk_data_wb !== 32'h0 || wbk_rd_reg_wb !== 1'b0 || rd_adr_wb !== 5'd0) begin n_fail++; $display("FAIL arst_wb: got %h/%b/%0d want 0/0/0", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb); end
        n_checks++; if (wbk_data_wb2 !== 32'h0 || wbk_rd_reg_wb2 !== 1'b0 || rd_adr_wb2 !== 5'd0) begin n_fail++; $display("FAIL arst_wb2: got %h/%b/%0d want 0/0/0", wbk_data_wb2, wbk_rd_reg_wb2, rd_adr_wb2); end
        n_checks++; if (dmem_if.req !== 1'b0 || ma_stall !== 1'b0 || dmem_if.be !== 4'b0000) begin n_fail++; $display("FAIL arst_bus: req %b stall %b be %b want 0", dmem_if.req, ma_stall, dmem_if.be); end
        @(negedge clk);
        rst = 1'b0;
        set_instr(1'b1, 1'b0, 5'd12, 32'h108, 1'b1, 32'h0, LDST_W);
        dmem_if.ack = 1'b1; dmem_if.rdata = 32'h600DCAFE;
        step();
        n_checks++; if (wbk_data_wb !== 32'h600DCAFE || rd_adr_wb !== 5'd12) begin n_fail++; $display("FAIL arst_recover: got %h/%0d want 600dcafe/12", wbk_data_wb, rd_adr_wb); end
        bubble(); dmem_if.ack = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        rst_pipe = 1'b0;
        ext_stall = 1'b0;
        dmem_if.ack = 1'b0;
        dmem_if.rdata = 32'h0;
        bubble();
        test_reset();
        test_lw_zero_wait();
        test_load_extend();
        test_store_wait();
        test_fault();
        test_hold();
        test_drop();
        test_rst_pipe_idle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
